// File: rtl/ksa_pkg.sv
// Shared types for the RC4 key-scheduling engine.
package ksa_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    SH_RD_I,
    SH_LAT_I,
    SH_RD_J,
    SH_LAT_J,
    SH_WR_I,
    SH_WR_J,
    DONE
  } ksa_state_t;

  function automatic logic is_busy(input ksa_state_t s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/ksa_key_sel.sv
// Latched key storage and wrapping key-byte index for the KSA shuffle.
module ksa_key_sel
  import ksa_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int LEN_W     = $clog2(KEY_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [LEN_W-1:0]       key_len,
  input  logic                   advance,
  input  logic                   clear,
  output logic [DATA_W-1:0]      key_byte
);

  logic [8*KEY_BYTES-1:0] key_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       k;
  logic [7:0]             byte_sel;

  // Out-of-range lengths collapse to the full key so k always has a valid wrap point.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      len_q <= '0;
      k     <= '0;
    end else if (load) begin
      key_q <= key;
      len_q <= ((key_len == '0) || (key_len > LEN_W'(KEY_BYTES))) ? LEN_W'(KEY_BYTES) : key_len;
      k     <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (advance) begin
      k <= (k == len_q - LEN_W'(1)) ? '0 : k + LEN_W'(1);
    end
  end

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == LEN_W'(b)) byte_sel = key_q[8*(KEY_BYTES-b)-1 -: 8];
    end
  end

  assign key_byte = DATA_W'(byte_sel);

endmodule

// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: identity init of the state RAM, then the KSA swap pass.
module ksa_engine
  import ksa_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3,
  localparam int LEN_W    = $clog2(KEY_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   skip_init,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [LEN_W-1:0]       key_len,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic                   done
);

  ksa_state_t        state, state_n;
  logic [DATA_W-1:0] i, j, si, sj;
  logic [DATA_W-1:0] key_byte;
  logic              accept;
  logic              wren_c;

  assign accept = ((state == IDLE) || (state == DONE)) && start;

  ksa_key_sel #(
    .DATA_W   (DATA_W),
    .KEY_BYTES(KEY_BYTES),
    .LEN_W    (LEN_W)
  ) u_key_sel (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .key     (key),
    .key_len (key_len),
    .advance (state == SH_WR_J),
    .clear   (state == INIT),
    .key_byte(key_byte)
  );

  // i wraps to 0 on its own after N-1, which is exactly the start index for the next phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: if (start) begin
          i <= '0;
          j <= '0;
        end
        INIT:     i  <= i + DATA_W'(1);
        SH_LAT_I: begin
          si <= mem_rdata;
          j  <= j + mem_rdata + key_byte;
        end
        SH_LAT_J: sj <= mem_rdata;
        SH_WR_J:  i  <= i + DATA_W'(1);
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    mem_addr  = '0;
    mem_wdata = '0;
    wren_c    = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_n = skip_init ? SH_RD_I : INIT;
      INIT: begin
        mem_addr  = i;
        mem_wdata = i;
        wren_c    = 1'b1;
        if (&i) state_n = SH_RD_I;
      end
      SH_RD_I: begin
        mem_addr = i;
        state_n  = SH_LAT_I;
      end
      SH_LAT_I: begin
        mem_addr = i;
        state_n  = SH_RD_J;
      end
      SH_RD_J: begin
        mem_addr = j;
        state_n  = SH_LAT_J;
      end
      SH_LAT_J: begin
        mem_addr = j;
        state_n  = SH_WR_I;
      end
      SH_WR_I: begin
        mem_addr  = i;
        mem_wdata = sj;
        wren_c    = 1'b1;
        state_n   = SH_WR_J;
      end
      SH_WR_J: begin
        mem_addr  = j;
        mem_wdata = si;
        wren_c    = 1'b1;
        state_n   = (&i) ? DONE : SH_RD_I;
      end
      default: state_n = IDLE;
    endcase
  end

  // A reset landing on a write cycle must not corrupt the RAM on that same edge.
  assign mem_wren = wren_c & ~reset;
  assign busy     = is_busy(state);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_ksa_engine.sv
// Directed bench for ksa_engine: an 8-bit instance and a 4-bit skip-init instance, each on a model RAM.
module tb_ksa_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start8 = 1'b0, skip8 = 1'b0;
  logic [23:0] key8 = '0;
  logic [1:0]  len8 = '0;
  logic [7:0]  addr8, wdata8, rdata8;
  logic        wren8, busy8, done8;

  logic        start4 = 1'b0, skip4 = 1'b0;
  logic [23:0] key4 = '0;
  logic [1:0]  len4 = '0;
  logic [3:0]  addr4, wdata4, rdata4;
  logic        wren4, busy4, done4;

  logic [7:0]  mem8 [256];
  logic [3:0]  mem4 [16];
  logic        preload4 = 1'b0;
  int          wr_cnt8;

  int checks = 0;
  int failures = 0;
  int exp_s [256];

  always #5 clk = ~clk;

  ksa_engine #(.DATA_W(8), .KEY_BYTES(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .skip_init(skip8), .key(key8), .key_len(len8),
    .mem_addr(addr8), .mem_wdata(wdata8), .mem_wren(wren8), .mem_rdata(rdata8),
    .busy(busy8), .done(done8)
  );

  ksa_engine #(.DATA_W(4), .KEY_BYTES(3)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .skip_init(skip4), .key(key4), .key_len(len4),
    .mem_addr(addr4), .mem_wdata(wdata4), .mem_wren(wren4), .mem_rdata(rdata4),
    .busy(busy4), .done(done4)
  );

  always @(posedge clk) begin
    if (wren8) mem8[addr8] <= wdata8;
    rdata8 <= mem8[addr8];
    if (wren8) wr_cnt8 <= wr_cnt8 + 1;
  end

  always @(posedge clk) begin
    if (preload4) begin
      for (int x = 0; x < 16; x++) mem4[x] <= 4'((x * 7 + 3) % 16);
    end else if (wren4) begin
      mem4[addr4] <= wdata4;
    end
    rdata4 <= mem4[addr4];
  end

  task automatic ksa_model(input int n, input logic [23:0] k, input int len);
    int jj, t, kb, el;
    el = (len == 0 || len > 3) ? 3 : len;
    jj = 0;
    for (int ii = 0; ii < n; ii++) begin
      kb = int'((k >> (8 * (2 - (ii % el)))) & 24'hFF) % n;
      jj = (jj + exp_s[ii] + kb) % n;
      t = exp_s[ii];
      exp_s[ii] = exp_s[jj];
      exp_s[jj] = t;
    end
  endtask

  task automatic run8(input logic [23:0] k, input logic [1:0] l, input logic s, output int cyc);
    @(negedge clk);
    key8 = k; len8 = l; skip8 = s; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr8, wdata8, wren8, busy8, done8} !== 19'd0) begin
      failures++;
      $display("FAIL reset8 outputs got %h want 0", {addr8, wdata8, wren8, busy8, done8});
    end
    checks++;
    if ({addr4, wdata4, wren4, busy4, done4} !== 11'd0) begin
      failures++;
      $display("FAIL reset4 outputs got %h want 0", {addr4, wdata4, wren4, busy4, done4});
    end
    reset = 1'b0;
  endtask

  task automatic test_init();
    int base;
    base = wr_cnt8;
    @(negedge clk);
    key8 = 24'h00033C; len8 = 2'd3; skip8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (!(busy8 === 1'b1 && wren8 === 1'b1 && addr8 === 8'd0 && wdata8 === 8'd0)) begin
      failures++;
      $display("FAIL init_first busy=%b wren=%b addr=%h wdata=%h want 1 1 00 00", busy8, wren8, addr8, wdata8);
    end
    repeat (256) @(negedge clk);
    checks++;
    if (!(busy8 === 1'b1 && wren8 === 1'b0)) begin
      failures++;
      $display("FAIL init_end busy=%b wren=%b want 1 0", busy8, wren8);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wr_cnt8 - base !== 256) begin
      failures++;
      $display("FAIL init_writes got %0d want 256", wr_cnt8 - base);
    end
    checks++;
    if (!(mem8[0] === 8'h00 && mem8[5] === 8'h05 && mem8[255] === 8'hFF)) begin
      failures++;
      $display("FAIL init_ram got %h %h %h want 00 05 ff", mem8[0], mem8[5], mem8[255]);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      failures++;
      $display("FAIL init_reset_busy got %b want 0", busy8);
    end
  endtask

  task automatic test_full_run();
    int cyc, base, bad;
    base = wr_cnt8;
    run8(24'h00033C, 2'd3, 1'b0, cyc);
    checks++;
    if (cyc !== 1793) begin
      failures++;
      $display("FAIL full_latency got %0d want 1793", cyc);
    end
    checks++;
    if (wr_cnt8 - base !== 768) begin
      failures++;
      $display("FAIL full_writes got %0d want 768", wr_cnt8 - base);
    end
    for (int x = 0; x < 256; x++) exp_s[x] = x;
    ksa_model(256, 24'h00033C, 3);
    for (int x = 0; x < 3; x++) begin
      checks++;
      if (int'(mem8[x]) !== exp_s[x]) begin
        failures++;
        $display("FAIL full_entry%0d got %h want %h", x, mem8[x], exp_s[x]);
      end
    end
    bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem8[x]) !== exp_s[x]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL full_ram mismatched_entries=%0d want 0", bad);
    end
  endtask

  task automatic test_key_len();
    int cyc, bad;
    for (int pass = 0; pass < 2; pass++) begin
      run8(24'h00033C, (pass == 0) ? 2'd1 : 2'd0, 1'b0, cyc);
      checks++;
      if (cyc !== 1793) begin
        failures++;
        $display("FAIL keylen%0d_latency got %0d want 1793", pass, cyc);
      end
      for (int x = 0; x < 256; x++) exp_s[x] = x;
      ksa_model(256, 24'h00033C, (pass == 0) ? 1 : 0);
      bad = 0;
      for (int x = 0; x < 256; x++) if (int'(mem8[x]) !== exp_s[x]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL keylen%0d_ram mismatched_entries=%0d want 0", pass, bad);
      end
    end
  endtask

  task automatic test_handshake();
    int cyc, bad;
    @(negedge clk);
    key8 = 24'h00033C; len8 = 2'd3; skip8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 4000) begin
      if (cyc == 10 || cyc == 500 || cyc == 1700) begin
        start8 = 1'b1; key8 = 24'hFFFFFF; len8 = 2'd1; skip8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    checks++;
    if (cyc !== 1793) begin
      failures++;
      $display("FAIL hs_latency got %0d want 1793", cyc);
    end
    for (int x = 0; x < 256; x++) exp_s[x] = x;
    ksa_model(256, 24'h00033C, 3);
    bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem8[x]) !== exp_s[x]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hs_ram mismatched_entries=%0d want 0", bad);
    end
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (done8 !== 1'b1 || busy8 !== 1'b0 || wren8 !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hs_done_hold bad_cycles=%0d want 0", bad);
    end
    key8 = 24'h00033C; len8 = 2'd3; skip8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    checks++;
    if (!(done8 === 1'b0 && busy8 === 1'b1)) begin
      failures++;
      $display("FAIL hs_restart done=%b busy=%b want 0 1", done8, busy8);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, snap, bad;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    key8 = 24'h00033C; len8 = 2'd3; skip8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (cyc < 900) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (!(busy8 === 1'b0 && done8 === 1'b0 && wren8 === 1'b0)) begin
      failures++;
      $display("FAIL midrst_outputs busy=%b done=%b wren=%b want 0 0 0", busy8, done8, wren8);
    end
    snap = wr_cnt8;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt8 !== snap || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet writes=%0d want 0 busy=%b", wr_cnt8 - snap, busy8);
    end
    run8(24'h00033C, 2'd3, 1'b0, cyc);
    checks++;
    if (cyc !== 1793) begin
      failures++;
      $display("FAIL midrst_latency got %0d want 1793", cyc);
    end
    for (int x = 0; x < 256; x++) exp_s[x] = x;
    ksa_model(256, 24'h00033C, 3);
    bad = 0;
    for (int x = 0; x < 256; x++) if (int'(mem8[x]) !== exp_s[x]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL midrst_ram mismatched_entries=%0d want 0", bad);
    end
  endtask

  task automatic test_skip4();
    int cyc, bad;
    @(negedge clk);
    preload4 = 1'b1;
    @(negedge clk);
    preload4 = 1'b0;
    key4 = 24'hA53C7E; len4 = 2'd3; skip4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if (!(busy4 === 1'b1 && wren4 === 1'b0)) begin
      failures++;
      $display("FAIL skip4_no_init busy=%b wren=%b want 1 0", busy4, wren4);
    end
    cyc = 1;
    while (!done4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 97) begin
      failures++;
      $display("FAIL skip4_latency got %0d want 97", cyc);
    end
    for (int x = 0; x < 16; x++) exp_s[x] = (x * 7 + 3) % 16;
    ksa_model(16, 24'hA53C7E, 3);
    bad = 0;
    for (int x = 0; x < 16; x++) if (int'(mem4[x]) !== exp_s[x]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL skip4_ram mismatched_entries=%0d want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_full_run();
    test_key_len();
    test_handshake();
    test_mid_reset();
    test_skip4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
